// File: rtl/if_prefetch.sv
// if_prefetch: instruction-fetch stage with a DEPTH-entry prefetch queue.
//
// Issues sequential word fetches to instruction memory while the queue has
// room. It hands {instruction, pc} pairs to ID over a valid/ready handshake.
// A branch redirect flushes the queue and drops any response still in flight.
//
// Ports
//   clk            rising-edge clock
//   resetn_i       asynchronous active-low reset
//   ID_IF_get_i    ID ready to accept an instruction
//   IF_ID_give_o   instruction valid towards ID (forced low in a branch cycle)
//   IF_ID_instr_o  instruction at the queue head
//   IF_ID_pc_o     address of IF_ID_instr_o
//   branch_i       redirect request
//   branch_addr_i  redirect target (bits [1:0] ignored)
//   MEM_addr_o     fetch address, stable while MEM_read_o is high
//   MEM_read_o     fetch request
//   MEM_data_i     fetch data, sampled when MEM_valid_i is high
//   MEM_valid_i    fetch response valid
module if_prefetch #(
  parameter int                 BITSIZE  = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [BITSIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               resetn_i,
  input  logic               ID_IF_get_i,
  output logic               IF_ID_give_o,
  output logic [31:0]        IF_ID_instr_o,
  output logic [BITSIZE-1:0] IF_ID_pc_o,
  input  logic               branch_i,
  input  logic [BITSIZE-1:0] branch_addr_i,
  output logic [BITSIZE-1:0] MEM_addr_o,
  output logic               MEM_read_o,
  input  logic [31:0]        MEM_data_i,
  input  logic               MEM_valid_i
);

  localparam int                 PTR_W   = $clog2(DEPTH);
  localparam int                 CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
  localparam logic [BITSIZE-1:0] STEP    = BITSIZE'(4);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [BITSIZE-1:0]   fetch_pc, fetch_pc_nxt;
  logic [BITSIZE-1:0]   req_addr, req_addr_nxt;
  logic [CNT_W-1:0]     count, count_nxt;
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [BITSIZE-1:0]   target;
  logic                 push, pop;

  logic [31:0]          instr_q [DEPTH];
  logic [BITSIZE-1:0]   pc_q    [DEPTH];

  function automatic logic [BITSIZE-1:0] word_align(input logic [BITSIZE-1:0] a);
    return a & ~BITSIZE'(3);
  endfunction

  assign target = word_align(branch_addr_i);

  // A response arriving together with a branch belongs to the old stream.
  assign push = (state == REQ) && MEM_valid_i && !branch_i;

  assign IF_ID_give_o  = (count != '0) && !branch_i;
  assign pop           = IF_ID_give_o && ID_IF_get_i;
  assign IF_ID_instr_o = instr_q[rd_ptr];
  assign IF_ID_pc_o    = pc_q[rd_ptr];

  assign MEM_read_o = (state == REQ) || (state == DISCARD);
  assign MEM_addr_o = req_addr;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  // Fetch FSM. A new request is only kept going when the slot for its
  // response is already guaranteed (count_nxt < DEPTH), so push never
  // overflows the queue.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    case (state)
      IDLE: begin
        if (branch_i) begin
          fetch_pc_nxt = target;
        end else if (count < DEPTH_C) begin
          req_addr_nxt = fetch_pc;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (branch_i) begin
          fetch_pc_nxt = target;
          // Without a response this cycle the request is still outstanding
          // and must be waited out, unchanged, in DISCARD.
          state_nxt    = MEM_valid_i ? IDLE : DISCARD;
        end else if (MEM_valid_i) begin
          fetch_pc_nxt = req_addr + STEP;
          if (count_nxt < DEPTH_C) begin
            req_addr_nxt = req_addr + STEP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DISCARD: begin
        if (branch_i) begin
          fetch_pc_nxt = target;
        end
        if (MEM_valid_i) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
      if (branch_i) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_nxt;
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Queue storage carries no reset; count qualifies every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr] <= MEM_data_i;
      pc_q[wr_ptr]    <= req_addr;
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
module tb_if_prefetch;

  localparam int          BITSIZE  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic        ID_IF_get_i;
  logic        IF_ID_give_o;
  logic [31:0] IF_ID_instr_o;
  logic [31:0] IF_ID_pc_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic [31:0] MEM_addr_o;
  logic        MEM_read_o;
  logic [31:0] MEM_data_i;
  logic        MEM_valid_i;

  always #5 clk = ~clk;

  if_prefetch #(
    .BITSIZE (BITSIZE),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk          (clk),
    .resetn_i     (resetn_i),
    .ID_IF_get_i  (ID_IF_get_i),
    .IF_ID_give_o (IF_ID_give_o),
    .IF_ID_instr_o(IF_ID_instr_o),
    .IF_ID_pc_o   (IF_ID_pc_o),
    .branch_i     (branch_i),
    .branch_addr_i(branch_addr_i),
    .MEM_addr_o   (MEM_addr_o),
    .MEM_read_o   (MEM_read_o),
    .MEM_data_i   (MEM_data_i),
    .MEM_valid_i  (MEM_valid_i)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  int          lat;
  int          wait_cnt;
  int          n_resp;
  int          n_xfer;
  logic        stale;
  logic [31:0] exp_req;
  logic        prev_read, prev_valid;
  logic [31:0] prev_addr;
  logic [31:0] last_resp_addr;
  logic        got_first;
  logic [31:0] first_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_req    = RESET_PC;
    stale      = 1'b0;
    wait_cnt   = 0;
    prev_read  = 1'b0;
    prev_valid = 1'b0;
    prev_addr  = RESET_PC;
    n_resp     = 0;
    n_xfer     = 0;
    got_first  = 1'b0;
    first_pc   = 32'hFFFF_FFFF;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn_i      = 1'b0;
    ID_IF_get_i   = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    MEM_valid_i   = 1'b0;
    MEM_data_i    = 32'hDEAD_BEEF;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_read", MEM_read_o, 1'b0);
    chk("rst_give", IF_ID_give_o, 1'b0);
    chk("rst_addr", MEM_addr_o, RESET_PC);
    resetn_i = 1'b1;
  endtask

  // One clock cycle: drive inputs at the falling edge, respond as memory,
  // then predict and check what the coming rising edge will do.
  task automatic cycle(input logic get_v, input logic br_v, input logic [31:0] br_a);
    logic exp_give;
    @(negedge clk);
    ID_IF_get_i   = get_v;
    branch_i      = br_v;
    branch_addr_i = br_a;
    if (MEM_read_o && wait_cnt >= lat) begin
      MEM_valid_i = 1'b1;
      MEM_data_i  = mem_word(MEM_addr_o);
    end else begin
      MEM_valid_i = 1'b0;
      MEM_data_i  = 32'hDEAD_BEEF;
    end
    #1;
    if (prev_read && !prev_valid && MEM_read_o)
      chk("addr_hold", MEM_addr_o, prev_addr);
    exp_give = (sb_q.size() != 0) && !br_v;
    chk("give", IF_ID_give_o, exp_give);
    if (exp_give && get_v) begin
      item_t it;
      it = sb_q.pop_front();
      chk("pc", IF_ID_pc_o, it.pc);
      chk("instr", IF_ID_instr_o, it.instr);
      n_xfer++;
      if (!got_first) begin
        got_first = 1'b1;
        first_pc  = it.pc;
      end
    end
    if (MEM_valid_i) begin
      n_resp++;
      if (br_v || stale) begin
        stale = 1'b0;
      end else begin
        chk("req_addr", MEM_addr_o, exp_req);
        chk("room", sb_q.size() < DEPTH, 1'b1);
        sb_q.push_back({mem_word(exp_req), exp_req});
        last_resp_addr = exp_req;
        exp_req = exp_req + 32'd4;
      end
    end
    if (br_v) begin
      sb_q.delete();
      exp_req = br_a & ~32'h3;
      stale   = MEM_read_o && !MEM_valid_i;
    end
    wait_cnt   = (MEM_read_o && !MEM_valid_i) ? wait_cnt + 1 : 0;
    prev_read  = MEM_read_o;
    prev_valid = MEM_valid_i;
    prev_addr  = MEM_addr_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn_i      = 1'b0;
    ID_IF_get_i   = 1'b0;
    branch_i      = 1'b0;
    branch_addr_i = 32'h0;
    MEM_valid_i   = 1'b0;
    MEM_data_i    = 32'h0;
    last_resp_addr = 32'h0;
    lat = 0;
    model_reset();

    // Zero-wait streaming with ID always ready.
    do_reset();
    lat = 0;
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    chk("t1_resp", n_resp, 6);
    chk("t1_xfer", n_xfer, 5);
    chk("t1_first_pc", first_pc, 32'h0);

    // Fill to DEPTH with ID stalled, then a single pop.
    do_reset();
    lat = 0;
    repeat (8) cycle(1'b0, 1'b0, 32'h0);
    chk("t2_resp", n_resp, DEPTH);
    chk("t2_read_full", MEM_read_o, 1'b0);
    chk("t2_give_full", IF_ID_give_o, 1'b1);
    cycle(1'b1, 1'b0, 32'h0);
    chk("t2_pop_pc", first_pc, 32'h0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0);
    chk("t2_refill", last_resp_addr, 32'h10);
    chk("t2_read_refull", MEM_read_o, 1'b0);
    repeat (6) cycle(1'b1, 1'b0, 32'h0);

    // Branch while a slow request is outstanding.
    do_reset();
    lat = 3;
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h100);
    repeat (20) cycle(1'b1, 1'b0, 32'h0);
    chk("t3_first_pc", first_pc, 32'h100);

    // Branch coincident with a response and a ready handshake.
    do_reset();
    lat = 0;
    repeat (4) cycle(1'b1, 1'b0, 32'h0);
    got_first = 1'b0;
    cycle(1'b1, 1'b1, 32'h203);
    repeat (8) cycle(1'b1, 1'b0, 32'h0);
    chk("t4_first_pc", first_pc, 32'h200);

    // Random ID stalls with mixed latencies; near-full push/pop overlap.
    do_reset();
    for (int i = 0; i < 240; i++) begin
      lat = (i / 40) % 3;
      cycle(($urandom_range(0, 3) != 0), 1'b0, 32'h0);
    end
    chk("t5_moved", n_xfer > 100, 1'b1);

    // PC wraps past the top of the address space.
    do_reset();
    lat = 0;
    cycle(1'b1, 1'b1, 32'hFFFF_FFF4);
    repeat (10) cycle(1'b1, 1'b0, 32'h0);
    chk("t6_first_pc", first_pc, 32'hFFFF_FFF4);
    chk("t6_wrapped", n_xfer >= 5, 1'b1);

    // Asynchronous reset between edges with a request pending.
    do_reset();
    lat = 0;
    repeat (2) cycle(1'b0, 1'b0, 32'h0);
    lat = 3;
    cycle(1'b0, 1'b0, 32'h0);
    chk("t7_pending", MEM_read_o, 1'b1);
    #2;
    resetn_i = 1'b0;
    #1;
    chk("t7_read_async", MEM_read_o, 1'b0);
    chk("t7_give_async", IF_ID_give_o, 1'b0);
    chk("t7_addr_async", MEM_addr_o, RESET_PC);
    MEM_valid_i = 1'b0;
    model_reset();
    @(negedge clk);
    resetn_i = 1'b1;
    lat = 0;
    repeat (6) cycle(1'b1, 1'b0, 32'h0);
    chk("t7_first_pc", first_pc, RESET_PC);
    chk("t7_xfer", n_xfer, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
